// File: rtl/id_scoreboard_if.sv
//------------------------------------------------------------------------------
// Module   : id_scoreboard_if
// Brief    : Decode-stage hazard scoreboard bus. The master side is ID
//            (issue info, operand reads, flush); the slave side is the
//            scoreboard (hazards, stall request, pending mask, perf count).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface id_scoreboard_if #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32,
   parameter int LAT_W      = 3,
   parameter int PERF_W     = 16
);
   // Issue of the instruction leaving ID
   logic                  issue_valid_i;
   logic                  issue_wreg_i;
   logic [REG_ADDR_W-1:0] issue_wd_i;
   logic                  issue_whilo_i;
   logic [LAT_W-1:0]      issue_lat_i;
   // Operand reads of the instruction sitting in ID
   logic                  reg1_read_i;
   logic [REG_ADDR_W-1:0] reg1_addr_i;
   logic                  reg2_read_i;
   logic [REG_ADDR_W-1:0] reg2_addr_i;
   logic                  read_hilo_i;
   logic                  flush_i;
   // Scoreboard results
   logic                  stallreq_o;
   logic                  reg1_hazard_o;
   logic                  reg2_hazard_o;
   logic                  hilo_hazard_o;
   logic [NUM_REGS-1:0]   pending_o;
   logic [PERF_W-1:0]     stall_cycles_o;

   modport master (
      output issue_valid_i, issue_wreg_i, issue_wd_i, issue_whilo_i, issue_lat_i,
      output reg1_read_i, reg1_addr_i, reg2_read_i, reg2_addr_i, read_hilo_i,
      output flush_i,
      input  stallreq_o, reg1_hazard_o, reg2_hazard_o, hilo_hazard_o,
      input  pending_o, stall_cycles_o
   );

   modport slave (
      input  issue_valid_i, issue_wreg_i, issue_wd_i, issue_whilo_i, issue_lat_i,
      input  reg1_read_i, reg1_addr_i, reg2_read_i, reg2_addr_i, read_hilo_i,
      input  flush_i,
      output stallreq_o, reg1_hazard_o, reg2_hazard_o, hilo_hazard_o,
      output pending_o, stall_cycles_o
   );
endinterface

`default_nettype wire

// File: rtl/id_scoreboard.sv
//------------------------------------------------------------------------------
// Module   : id_scoreboard
// Brief    : Register-hazard scoreboard for the decode stage. One down-counter
//            per GPR (r0 excluded) and one for HI/LO hold the number of cycles
//            until an in-flight result becomes bypassable; ID is held while it
//            reads a register whose counter is nonzero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module id_scoreboard #(
   parameter int REG_ADDR_W = 5,
   parameter int NUM_REGS   = 32,
   parameter int LAT_W      = 3,
   parameter int PERF_W     = 16
) (
   input  wire logic      clk,
   input  wire logic      rst,     // asynchronous, active low
   id_scoreboard_if.slave sb
);

   localparam logic [PERF_W-1:0] C_PERF_MAX = '1;

   logic                  w_accept;
   logic                  w_lat_nz;
   logic                  w_stallreq;
   logic                  w_reg1_hazard;
   logic                  w_reg2_hazard;
   logic                  w_hilo_hazard;
   logic                  w_rd1_pend;
   logic                  w_rd2_pend;
   logic [NUM_REGS-1:0]   w_pending;
   logic [LAT_W-1:0]      r_cnt_hilo;
   logic [PERF_W-1:0]     r_stall_cycles;

   // An issue only counts when ID is actually allowed to advance.
   assign w_accept = sb.issue_valid_i && !w_stallreq && !sb.flush_i;
   assign w_lat_nz = |sb.issue_lat_i;

   // r0 is hard-wired and never pending.
   assign w_pending[0] = 1'b0;

   generate
      for (genvar i = 1; i < NUM_REGS; i++) begin : g_cnt
         logic [LAT_W-1:0] r_cnt;
         logic             w_load;

         assign w_load = w_accept && sb.issue_wreg_i && w_lat_nz &&
                         (sb.issue_wd_i == REG_ADDR_W'(i));

         // Per-GPR latency counter: flush clears, load beats decrement, floor at 0.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_cnt <= '0;
            end else if (sb.flush_i) begin
               r_cnt <= '0;
            end else if (w_load) begin
               r_cnt <= sb.issue_lat_i;
            end else if (r_cnt != '0) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end

         assign w_pending[i] = |r_cnt;
      end
   endgenerate

   // HI/LO latency counter with the same priority as the GPR counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt_hilo <= '0;
      end else if (sb.flush_i) begin
         r_cnt_hilo <= '0;
      end else if (w_accept && sb.issue_whilo_i && w_lat_nz) begin
         r_cnt_hilo <= sb.issue_lat_i;
      end else if (r_cnt_hilo != '0) begin
         r_cnt_hilo <= r_cnt_hilo - 1'b1;
      end
   end

   // Operand lookup by compare, so addresses beyond NUM_REGS (and r0) read as idle.
   always_comb begin
      w_rd1_pend = 1'b0;
      w_rd2_pend = 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (sb.reg1_addr_i == REG_ADDR_W'(i)) w_rd1_pend = w_pending[i];
         if (sb.reg2_addr_i == REG_ADDR_W'(i)) w_rd2_pend = w_pending[i];
      end
   end

   assign w_reg1_hazard = sb.reg1_read_i && (sb.reg1_addr_i != '0) && w_rd1_pend;
   assign w_reg2_hazard = sb.reg2_read_i && (sb.reg2_addr_i != '0) && w_rd2_pend;
   assign w_hilo_hazard = sb.read_hilo_i && (r_cnt_hilo != '0);

   // A flushed instruction is discarded anyway, so it must not hold the pipe.
   assign w_stallreq = (w_reg1_hazard || w_reg2_hazard || w_hilo_hazard) && !sb.flush_i;

   // Saturating count of stalled cycles; deliberately survives flushes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cycles <= '0;
      end else if (w_stallreq && (r_stall_cycles != C_PERF_MAX)) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign sb.stallreq_o     = w_stallreq;
   assign sb.reg1_hazard_o  = w_reg1_hazard;
   assign sb.reg2_hazard_o  = w_reg2_hazard;
   assign sb.hilo_hazard_o  = w_hilo_hazard;
   assign sb.pending_o      = w_pending;
   assign sb.stall_cycles_o = r_stall_cycles;

endmodule

`default_nettype wire
